sc_win_level_controller: RTL

// - Game-flow sequencer for the Frogger datapath: consumes the active-low "frog reached goal" flag

---
 rtl/sc_win_level_controller_if.sv | 39 +++
 rtl/sc_win_level_controller.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sc_win_level_controller_if.sv
// Game-flow bus between the Frogger datapath and the win/level controller.
// The datapath side is the master (drives buttons and flags); the controller is the slave.
interface sc_win_level_controller_if #(
    parameter int unsigned LEVEL_WIDTH = 3
);
    logic                   SC_WINCTRL_start_InLow;
    logic                   SC_WINCTRL_win_InLow;
    logic                   SC_WINCTRL_hit_InLow;
    logic [LEVEL_WIDTH-1:0] SC_WINCTRL_level_OutBUS;
    logic [1:0]             SC_WINCTRL_lives_OutBUS;
    logic [2:0]             SC_WINCTRL_state_OutBUS;
    logic                   SC_WINCTRL_run_Out;
    logic                   SC_WINCTRL_frogRst_OutLow;
    logic                   SC_WINCTRL_levelUp_OutLow;

    modport master (
        output SC_WINCTRL_start_InLow,
        output SC_WINCTRL_win_InLow,
        output SC_WINCTRL_hit_InLow,
        input  SC_WINCTRL_level_OutBUS,
        input  SC_WINCTRL_lives_OutBUS,
        input  SC_WINCTRL_state_OutBUS,
        input  SC_WINCTRL_run_Out,
        input  SC_WINCTRL_frogRst_OutLow,
        input  SC_WINCTRL_levelUp_OutLow
    );

    modport slave (
        input  SC_WINCTRL_start_InLow,
        input  SC_WINCTRL_win_InLow,
        input  SC_WINCTRL_hit_InLow,
        output SC_WINCTRL_level_OutBUS,
        output SC_WINCTRL_lives_OutBUS,
        output SC_WINCTRL_state_OutBUS,
        output SC_WINCTRL_run_Out,
        output SC_WINCTRL_frogRst_OutLow,
        output SC_WINCTRL_levelUp_OutLow
    );
endinterface

// File: rtl/sc_win_level_controller.sv
// Frogger game-flow sequencer: sequences levels, lives and the hold pauses that
// follow a win or a hit, and drives the movement enable and frog-return pulses.
module sc_win_level_controller #(
    parameter int unsigned LEVEL_WIDTH = 3,
    parameter int unsigned MAX_LEVEL   = 4,
    parameter int unsigned LIVES_INIT  = 3,
    parameter int unsigned HOLD_CYCLES = 25000000
) (
    input  logic                    SC_WINCTRL_CLOCK_50,
    input  logic                    SC_WINCTRL_RESET_InLow,
    sc_win_level_controller_if.slave bus
);

    localparam int unsigned TIMER_WIDTH = $clog2(HOLD_CYCLES);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        WIN_HOLD  = 3'd2,
        LOSE_HOLD = 3'd3,
        GAME_OVER = 3'd4,
        CHAMPION  = 3'd5
    } state_t;

    state_t                 state;
    logic [LEVEL_WIDTH-1:0] level;
    logic [1:0]             lives;
    logic                   run;
    logic                   frog_rst_n;
    logic                   level_up_n;
    logic                   play_guard;
    logic                   start_q;
    logic [TIMER_WIDTH-1:0] hold_timer;

    logic start_event;
    logic hold_done;
    logic at_top_level;

    assign start_event  = start_q & ~bus.SC_WINCTRL_start_InLow;
    assign hold_done    = (hold_timer == TIMER_WIDTH'(HOLD_CYCLES - 1));
    assign at_top_level = (level == LEVEL_WIDTH'(MAX_LEVEL - 1));

    // Start button history: an event is a 1 -> 0 transition, so a held button fires once.
    always_ff @(posedge SC_WINCTRL_CLOCK_50 or negedge SC_WINCTRL_RESET_InLow) begin
        if (!SC_WINCTRL_RESET_InLow) begin
            start_q <= 1'b1;
        end else begin
            start_q <= bus.SC_WINCTRL_start_InLow;
        end
    end

    // Game-flow FSM with registered outputs; pulses default high and are lowered for one cycle.
    always_ff @(posedge SC_WINCTRL_CLOCK_50 or negedge SC_WINCTRL_RESET_InLow) begin
        if (!SC_WINCTRL_RESET_InLow) begin
            state      <= IDLE;
            level      <= '0;
            lives      <= 2'(LIVES_INIT);
            run        <= 1'b0;
            frog_rst_n <= 1'b1;
            level_up_n <= 1'b1;
            play_guard <= 1'b0;
            hold_timer <= '0;
        end else begin
            frog_rst_n <= 1'b1;
            level_up_n <= 1'b1;
            case (state)
                IDLE, GAME_OVER, CHAMPION: begin
                    run <= 1'b0;
                    if (start_event) begin
                        level      <= '0;
                        lives      <= 2'(LIVES_INIT);
                        state      <= PLAY;
                        run        <= 1'b1;
                        frog_rst_n <= 1'b0;
                        play_guard <= 1'b1;
                    end
                end
                PLAY: begin
                    if (play_guard) begin
                        play_guard <= 1'b0;
                    end else if (!bus.SC_WINCTRL_win_InLow) begin
                        state      <= WIN_HOLD;
                        run        <= 1'b0;
                        hold_timer <= '0;
                    end else if (!bus.SC_WINCTRL_hit_InLow) begin
                        state      <= LOSE_HOLD;
                        run        <= 1'b0;
                        hold_timer <= '0;
                        if (lives != 2'd0) begin
                            lives <= lives - 2'd1;
                        end
                    end
                end
                WIN_HOLD: begin
                    if (hold_done) begin
                        if (at_top_level) begin
                            state <= CHAMPION;
                        end else begin
                            level      <= level + LEVEL_WIDTH'(1);
                            level_up_n <= 1'b0;
                            state      <= PLAY;
                            run        <= 1'b1;
                            frog_rst_n <= 1'b0;
                            play_guard <= 1'b1;
                        end
                    end else begin
                        hold_timer <= hold_timer + TIMER_WIDTH'(1);
                    end
                end
                LOSE_HOLD: begin
                    if (hold_done) begin
                        if (lives == 2'd0) begin
                            state <= GAME_OVER;
                        end else begin
                            state      <= PLAY;
                            run        <= 1'b1;
                            frog_rst_n <= 1'b0;
                            play_guard <= 1'b1;
                        end
                    end else begin
                        hold_timer <= hold_timer + TIMER_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    run   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.SC_WINCTRL_level_OutBUS   = level;
    assign bus.SC_WINCTRL_lives_OutBUS   = lives;
    assign bus.SC_WINCTRL_state_OutBUS   = state;
    assign bus.SC_WINCTRL_run_Out        = run;
    assign bus.SC_WINCTRL_frogRst_OutLow = frog_rst_n;
    assign bus.SC_WINCTRL_levelUp_OutLow = level_up_n;

endmodule
